// File: rtl/onewire_master_phy.sv
// 1-Wire master bit-slot timing engine: one RESET/WRITE0/WRITE1/READ slot per accepted command,
// driving an open-drain pad through its I/T pins and sampling its O pin.
module onewire_master_phy #(
  parameter int unsigned CLKS_PER_US = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] cmd,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic       done,
  output logic       rx_bit,
  output logic       presence,
  output logic       bus_error,
  input  logic       io_i,
  output logic       io_o,
  output logic       io_t
);

  localparam int unsigned PW = 16;
  localparam int unsigned UW = 10;

  localparam logic [1:0] CMD_RESET  = 2'b00;
  localparam logic [1:0] CMD_WRITE0 = 2'b01;
  localparam logic [1:0] CMD_WRITE1 = 2'b10;
  localparam logic [1:0] CMD_READ   = 2'b11;

  localparam logic [PW-1:0] PRE_LAST = PW'(CLKS_PER_US - 1);

  typedef enum logic {IDLE, SLOT} state_t;

  state_t        state_q, state_d;
  logic [1:0]    cmd_q, cmd_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [UW-1:0] us_q, us_d;
  logic          rx_bit_q, rx_bit_d;
  logic          presence_q, presence_d;
  logic          bus_error_q, bus_error_d;
  logic          done_q, done_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          io_t_q, io_t_d;
  logic          sync1_q, sync2_q;
  logic          sample_hit, end_hit;

  // Microseconds the line is held low for each slot type.
  function automatic logic [UW-1:0] low_us(input logic [1:0] c);
    case (c)
      CMD_RESET:  low_us = 10'd480;
      CMD_WRITE0: low_us = 10'd60;
      default:    low_us = 10'd6;
    endcase
  endfunction

  // Total slot length in microseconds.
  function automatic logic [UW-1:0] total_us(input logic [1:0] c);
    if (c == CMD_RESET) total_us = 10'd960;
    else                total_us = 10'd70;
  endfunction

  // Sample point in microseconds (only READ and RESET use it).
  function automatic logic [UW-1:0] sample_us(input logic [1:0] c);
    if (c == CMD_RESET) sample_us = 10'd550;
    else                sample_us = 10'd15;
  endfunction

  // Pad data is always low; the line is released via io_t.
  assign io_o      = 1'b0;
  assign cmd_ready = cmd_ready_q;
  assign done      = done_q;
  assign rx_bit    = rx_bit_q;
  assign presence  = presence_q;
  assign bus_error = bus_error_q;
  assign io_t      = io_t_q;

  // Slot sequencing, sampling and registered output decode.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    pre_d       = pre_q;
    us_d        = us_q;
    rx_bit_d    = rx_bit_q;
    presence_d  = presence_q;
    bus_error_d = bus_error_q;

    sample_hit = (state_q == SLOT) && (us_q == sample_us(cmd_q)) && (pre_q == '0)
                 && ((cmd_q == CMD_READ) || (cmd_q == CMD_RESET));
    end_hit    = (state_q == SLOT) && (us_q == total_us(cmd_q) - 10'd1) && (pre_q == PRE_LAST);

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d = SLOT;
          cmd_d   = cmd;
          pre_d   = '0;
          us_d    = '0;
        end
      end
      SLOT: begin
        if (end_hit) begin
          state_d     = IDLE;
          pre_d       = '0;
          us_d        = '0;
          bus_error_d = ~sync2_q;
        end else if (pre_q == PRE_LAST) begin
          pre_d = '0;
          us_d  = us_q + 10'd1;
        end else begin
          pre_d = pre_q + 16'd1;
        end
        if (sample_hit) begin
          if (cmd_q == CMD_READ) rx_bit_d   = sync2_q;
          else                   presence_d = ~sync2_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs registered from next-state so they track the slot position exactly.
    io_t_d      = !((state_d == SLOT) && (us_d < low_us(cmd_d)));
    done_d      = (state_d == SLOT) && (us_d == total_us(cmd_d) - 10'd1) && (pre_d == PRE_LAST);
    cmd_ready_d = (state_d == IDLE);
  end

  // State, counters, outputs and the io_i synchronizer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cmd_q       <= CMD_RESET;
      pre_q       <= '0;
      us_q        <= '0;
      rx_bit_q    <= 1'b0;
      presence_q  <= 1'b0;
      bus_error_q <= 1'b0;
      done_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      io_t_q      <= 1'b1;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      pre_q       <= pre_d;
      us_q        <= us_d;
      rx_bit_q    <= rx_bit_d;
      presence_q  <= presence_d;
      bus_error_q <= bus_error_d;
      done_q      <= done_d;
      cmd_ready_q <= cmd_ready_d;
      io_t_q      <= io_t_d;
      sync1_q     <= io_i;
      sync2_q     <= sync1_q;
    end
  end

endmodule

// File: tb/tb_onewire_master_phy.sv
// Self-checking bench for onewire_master_phy using a slot-cycle-index model.
module tb_onewire_master_phy;

  localparam int unsigned C = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] cmd;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       done;
  logic       rx_bit;
  logic       presence;
  logic       bus_error;
  logic       io_i;
  logic       io_o;
  logic       io_t;

  onewire_master_phy #(.CLKS_PER_US(C)) dut (
    .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .done(done), .rx_bit(rx_bit), .presence(presence), .bus_error(bus_error),
    .io_i(io_i), .io_o(io_o), .io_t(io_t)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: slot position (k = 1..TOTAL*C), latched results, and 2-cycle line delay.
  bit         m_busy = 1'b0;
  int         m_k = 0;
  logic [1:0] m_cmd = 2'b00;
  logic       m_rx = 1'b0, m_pres = 1'b0, m_berr = 1'b0;
  logic       sd1 = 1'b1, sd2 = 1'b1;

  int pull_lo = 0, pull_hi = -1;
  bit stuck = 1'b0;
  int done_k = 0, low_end = 0;

  function automatic int lo_us(input logic [1:0] c);
    case (c)
      2'b00:   return 480;
      2'b01:   return 60;
      default: return 6;
    endcase
  endfunction

  function automatic int tot_us(input logic [1:0] c);
    return (c == 2'b00) ? 960 : 70;
  endfunction

  function automatic int smp_us(input logic [1:0] c);
    return (c == 2'b00) ? 550 : 15;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d want %0d", nm, $time, act, exp);
    end
  endtask

  // One clock cycle: compare all outputs, drive inputs, advance the model.
  task automatic step(input bit v, input logic [1:0] c, input bit rst);
    bit exp_t, exp_done, pulled, line, synced;
    @(posedge clk);
    #1;
    exp_t    = !(m_busy && (m_k <= lo_us(m_cmd) * C));
    exp_done = m_busy && (m_k == tot_us(m_cmd) * C);
    chk("cmd_ready", 32'(cmd_ready), 32'(!m_busy));
    chk("done", 32'(done), 32'(exp_done));
    chk("io_t", 32'(io_t), 32'(exp_t));
    chk("io_o", 32'(io_o), 32'd0);
    chk("rx_bit", 32'(rx_bit), 32'(m_rx));
    chk("presence", 32'(presence), 32'(m_pres));
    chk("bus_error", 32'(bus_error), 32'(m_berr));
    if (m_busy && done === 1'b1) done_k = m_k;
    if (m_busy && io_t === 1'b0) low_end = m_k;

    pulled = stuck || (m_busy && m_k >= pull_lo && m_k <= pull_hi);
    line   = exp_t && !pulled;
    cmd_valid = v;
    cmd       = c;
    reset     = rst;
    io_i      = line;

    synced = sd2;
    if (rst) begin
      m_busy = 1'b0; m_k = 0;
      m_rx = 1'b0; m_pres = 1'b0; m_berr = 1'b0;
      sd1 = 1'b1; sd2 = 1'b1;
    end else begin
      sd2 = sd1;
      sd1 = line;
      if (m_busy) begin
        if (m_k == smp_us(m_cmd) * C + 1) begin
          if (m_cmd == 2'b11) m_rx = synced;
          if (m_cmd == 2'b00) m_pres = !synced;
        end
        if (m_k == tot_us(m_cmd) * C) begin
          m_berr = !synced;
          m_busy = 1'b0;
          m_k    = 0;
        end else begin
          m_k++;
        end
      end else if (v) begin
        m_busy = 1'b1;
        m_k    = 1;
        m_cmd  = c;
      end
    end
  endtask

  // Issue a command and run until its slot ends (last step is the done cycle).
  task automatic run_cmd(input logic [1:0] c, input int plo, input int phi, input bit stk);
    pull_lo = plo; pull_hi = phi; stuck = stk;
    done_k = 0; low_end = 0;
    step(1'b1, c, 1'b0);
    for (int i = 0; i < 2500 && m_busy; i++) step(1'b0, 2'b00, 1'b0);
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd = 2'b00; io_i = 1'b1;
    repeat (3) @(posedge clk);
    step(1'b0, 2'b00, 1'b0);
    step(1'b0, 2'b00, 1'b0);

    // WRITE1 with healthy line
    run_cmd(2'b10, 0, -1, 1'b0);
    step(1'b0, 2'b00, 1'b0);
    chk("w1_done_k", 32'(done_k), 32'd140);
    chk("w1_low_end", 32'(low_end), 32'd12);
    chk("w1_berr", 32'(bus_error), 32'd0);

    // WRITE0 followed immediately by another WRITE0
    run_cmd(2'b01, 0, -1, 1'b0);
    chk("w0_low_end", 32'(low_end), 32'd120);
    run_cmd(2'b01, 0, -1, 1'b0);
    chk("w0b_done_k", 32'(done_k), 32'd140);
    step(1'b0, 2'b00, 1'b0);

    // READ with slave holding line low, then READ with released line
    run_cmd(2'b11, 1, 40, 1'b0);
    chk("rd0_rx", 32'(rx_bit), 32'd0);
    run_cmd(2'b11, 0, -1, 1'b0);
    chk("rd1_rx", 32'(rx_bit), 32'd1);

    // RESET with presence pulse
    run_cmd(2'b00, 1000, 1200, 1'b0);
    chk("rst_done_k", 32'(done_k), 32'd1920);
    chk("rst_low_end", 32'(low_end), 32'd960);
    chk("rst_pres", 32'(presence), 32'd1);

    // Reset mid-slot, with an ignored command pulse inside the slot
    pull_lo = 0; pull_hi = -1; stuck = 1'b0; done_k = 0;
    step(1'b1, 2'b00, 1'b0);
    for (int i = 0; i < 100 && m_k < 50; i++) step(m_k == 20, 2'b01, 1'b0);
    step(1'b0, 2'b00, 1'b1);
    step(1'b0, 2'b00, 1'b0);
    chk("mid_io_t", 32'(io_t), 32'd1);
    chk("mid_ready", 32'(cmd_ready), 32'd1);
    chk("mid_pres", 32'(presence), 32'd0);
    repeat (4) step(1'b0, 2'b00, 1'b0);
    chk("mid_no_done", 32'(done_k), 32'd0);

    // RESET with no device
    run_cmd(2'b00, 0, -1, 1'b0);
    chk("nodev_pres", 32'(presence), 32'd0);

    // Stuck-low READ, then healthy WRITE1 clears the error
    run_cmd(2'b11, 0, -1, 1'b1);
    step(1'b0, 2'b00, 1'b0);
    chk("stuck_rx", 32'(rx_bit), 32'd0);
    chk("stuck_berr", 32'(bus_error), 32'd1);
    run_cmd(2'b10, 0, -1, 1'b0);
    step(1'b0, 2'b00, 1'b0);
    chk("heal_berr", 32'(bus_error), 32'd0);
    step(1'b0, 2'b00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
